// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer and the pcnext block.
package pc_sequencer_pkg;

  // Decoder PC select; pcnext decodes the same encoding.
  typedef enum logic [1:0] {
    PC_INCREMENT = 2'b00,
    PC_BRANCH    = 2'b01,
    PC_JUMP      = 2'b10,
    PC_JR        = 2'b11
  } pc_sel_t;

  // Sequencer states, kept as plain constants for legacy tools.
  typedef logic [1:0] seq_state_t;
  localparam seq_state_t ST_RESET  = 2'd0;
  localparam seq_state_t ST_FETCH  = 2'd1;
  localparam seq_state_t ST_EXEC   = 2'd2;
  localparam seq_state_t ST_HALTED = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

  // True when the retiring control-flow instruction redirects after its delay slot.
  function automatic logic is_taken(input pc_sel_t sel, input logic cond);
    logic taken;
    case (sel)
      PC_INCREMENT: taken = 1'b0;
      PC_BRANCH:    taken = cond;
      PC_JUMP:      taken = 1'b1;
      PC_JR:        taken = 1'b1;
      default:      taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_redirect_latch.sv
// Holds the redirect target captured by a taken branch/jump until its delay slot retires.
module pc_redirect_latch
  import pc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        consume,
  input  logic        load,
  input  logic        set_dslot,
  input  logic        clr_dslot,
  input  logic [31:0] load_target,
  output logic [31:0] pend_target,
  output logic        pend_valid,
  output logic        dslot
);

  logic [31:0] target_r;
  logic        valid_r;
  logic        dslot_r;

  // Consuming the pending redirect wins over any load in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_r <= 32'h0000_0000;
      valid_r  <= 1'b0;
      dslot_r  <= 1'b0;
    end else if (consume) begin
      valid_r <= 1'b0;
      dslot_r <= 1'b0;
    end else begin
      if (set_dslot) begin
        dslot_r <= 1'b1;
      end else if (clr_dslot) begin
        dslot_r <= 1'b0;
      end else begin
        dslot_r <= dslot_r;
      end
      if (load) begin
        target_r <= load_target;
        valid_r  <= 1'b1;
      end else begin
        target_r <= target_r;
        valid_r  <= valid_r;
      end
    end
  end

  assign pend_target = target_r;
  assign pend_valid  = valid_r;
  assign dslot       = dslot_r;

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner: sequences FETCH/EXEC, applies delayed redirects, detects halt.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_waitrequest,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic        is_true,
  input  logic [31:0] pcnext_in,
  output logic        instr_read,
  output logic [31:0] instr_address,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic        delay_slot,
  output logic        active,
  output logic        err
);

  seq_state_t  state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic        err_r, err_nxt_s;
  logic        read_r, valid_r, active_r;
  logic        consume_s, load_s, set_dslot_s, clr_dslot_s;
  logic [31:0] pend_target_s;
  logic        pend_valid_s, dslot_s;
  logic [31:0] pc_inc_s;

  assign pc_inc_s = pc_r + 32'd4;

  // Next-state, next-PC and redirect-latch control; only an EXEC retire moves the PC.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    err_nxt_s   = err_r;
    consume_s   = 1'b0;
    load_s      = 1'b0;
    set_dslot_s = 1'b0;
    clr_dslot_s = 1'b0;
    case (state_r)
      ST_RESET: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (instr_waitrequest) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (stall) begin
          state_nxt_s = ST_EXEC;
        end else if (pend_valid_s) begin
          // Delay slot retiring: its own redirect request is ignored.
          consume_s = 1'b1;
          pc_nxt_s  = pend_target_s;
          if (pend_target_s == HALT_ADDR) begin
            state_nxt_s = ST_HALTED;
          end else if (is_misaligned(pend_target_s)) begin
            state_nxt_s = ST_HALTED;
            err_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else if (pc_sel_t'(pc_sel) != PC_INCREMENT) begin
          set_dslot_s = 1'b1;
          load_s      = is_taken(pc_sel_t'(pc_sel), is_true);
          pc_nxt_s    = pc_inc_s;
          state_nxt_s = ST_FETCH;
        end else begin
          clr_dslot_s = 1'b1;
          pc_nxt_s    = pc_inc_s;
          state_nxt_s = ST_FETCH;
        end
      end
      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
      end
      default: begin
        state_nxt_s = ST_RESET;
      end
    endcase
  end

  // State, PC, sticky error and registered output decode of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_RESET;
      pc_r     <= RESET_VECTOR;
      err_r    <= 1'b0;
      read_r   <= 1'b0;
      valid_r  <= 1'b0;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      err_r    <= err_nxt_s;
      read_r   <= (state_nxt_s == ST_FETCH);
      valid_r  <= (state_nxt_s == ST_EXEC);
      active_r <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_EXEC);
    end
  end

  pc_redirect_latch u_redirect (
    .clk         (clk),
    .reset       (reset),
    .consume     (consume_s),
    .load        (load_s),
    .set_dslot   (set_dslot_s),
    .clr_dslot   (clr_dslot_s),
    .load_target (pcnext_in),
    .pend_target (pend_target_s),
    .pend_valid  (pend_valid_s),
    .dslot       (dslot_s)
  );

  assign instr_read    = read_r;
  assign instr_valid   = valid_r;
  assign active        = active_r;
  assign err           = err_r;
  assign pc            = pc_r;
  assign instr_address = pc_r;
  assign delay_slot    = dslot_s;

endmodule
